// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game mode encodings and BCD helpers
package game_pkg;

    // FINISH encoding is shared with the high-score checker; keep 3'b101.
    typedef enum logic [2:0] {
        MODE_IDLE      = 3'b000,
        MODE_COUNTDOWN = 3'b001,
        MODE_PLAY      = 3'b010,
        MODE_PAUSE     = 3'b011,
        MODE_FINISH    = 3'b101
    } mode_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Two-digit saturating BCD increment; a units digit of 9 or above rolls
    // into tens so a non-BCD nibble can never be produced.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/game_mode_ctrl_if.sv
// rtl/game_mode_ctrl_if.sv - button/judge inputs and mode/score outputs of the sequencer
interface game_mode_ctrl_if #(
    parameter int MISS_W = 4
);
    import game_pkg::*;

    logic              start_btn;
    logic              pause_btn;
    logic              note_hit;
    logic              note_miss;
    logic              song_done;
    mode_t             mode;
    logic [7:0]        score;
    logic [MISS_W-1:0] miss_cnt;
    logic              score_tog;
    logic              play_en;

    modport master (
        output start_btn, pause_btn, note_hit, note_miss, song_done,
        input  mode, score, miss_cnt, score_tog, play_en
    );

    modport slave (
        input  start_btn, pause_btn, note_hit, note_miss, song_done,
        output mode, score, miss_cnt, score_tog, play_en
    );
endinterface

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - two-digit saturating BCD score register
module bcd_score_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] score
);

    logic [7:0] score_q;
    logic [7:0] score_d;

    // Clear wins over increment; otherwise hold.
    always_comb begin
        score_d = score_q;
        if (clr) begin
            score_d = 8'h00;
        end else if (inc) begin
            score_d = bcd_inc_sat(score_q);
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            score_q <= 8'h00;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// rtl/game_mode_ctrl.sv - guitar game sequencer: mode FSM, timers, score and miss count
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int COUNT_CYCLES = 30_000_000,
    parameter int TOG_CYCLES   = 10_000_000,
    parameter int MAX_MISS     = 10,
    parameter int MISS_W       = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    game_mode_ctrl_if.slave  bus
);

    localparam int CNT_W = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;
    localparam int TOG_W = (TOG_CYCLES > 1) ? $clog2(TOG_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT_CYCLES - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST = TOG_W'(TOG_CYCLES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);

    mode_t             mode_q, mode_d;
    logic              start_prev_q, start_prev_d;
    logic              pause_prev_q, pause_prev_d;
    logic [CNT_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic [TOG_W-1:0]  tog_cnt_q, tog_cnt_d;
    logic              score_tog_q, score_tog_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

    logic              start_edge;
    logic              pause_edge;
    logic              miss_inc;
    logic [MISS_W-1:0] miss_next;
    logic              miss_reach;
    logic              enter_cd;
    logic              score_inc;
    logic [7:0]        score;

    assign start_edge = bus.start_btn & ~start_prev_q;
    assign pause_edge = bus.pause_btn & ~pause_prev_q;

    // Miss counting happens only in PLAY and saturates at the limit.
    always_comb begin
        miss_inc   = (mode_q == MODE_PLAY) && bus.note_miss;
        miss_next  = miss_cnt_q;
        if (miss_inc && (miss_cnt_q != MISS_MAX)) begin
            miss_next = miss_cnt_q + MISS_W'(1);
        end
        miss_reach = miss_inc && (miss_next == MISS_MAX);
    end

    // Next mode and countdown timer; the countdown only runs while in COUNTDOWN.
    always_comb begin
        mode_d   = mode_q;
        cd_cnt_d = '0;
        case (mode_q)
            MODE_IDLE: begin
                if (start_edge) mode_d = MODE_COUNTDOWN;
            end
            MODE_COUNTDOWN: begin
                if (cd_cnt_q == CNT_LAST) begin
                    mode_d = MODE_PLAY;
                end else begin
                    cd_cnt_d = cd_cnt_q + CNT_W'(1);
                end
            end
            MODE_PLAY: begin
                if (bus.song_done || miss_reach) begin
                    mode_d = MODE_FINISH;
                end else if (pause_edge) begin
                    mode_d = MODE_PAUSE;
                end
            end
            MODE_PAUSE: begin
                if (start_edge) begin
                    mode_d = MODE_IDLE;
                end else if (pause_edge) begin
                    mode_d = MODE_PLAY;
                end
            end
            MODE_FINISH: begin
                if (start_edge) mode_d = MODE_COUNTDOWN;
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

    // Score/miss clear on COUNTDOWN entry; edge-detect history tracks the buttons.
    always_comb begin
        enter_cd     = (mode_d == MODE_COUNTDOWN) && (mode_q != MODE_COUNTDOWN);
        score_inc    = (mode_q == MODE_PLAY) && bus.note_hit;
        miss_cnt_d   = enter_cd ? '0 : miss_next;
        start_prev_d = bus.start_btn;
        pause_prev_d = bus.pause_btn;
    end

    // Display toggle runs only while staying in FINISH; entry and exit clear it.
    always_comb begin
        tog_cnt_d   = '0;
        score_tog_d = 1'b0;
        if ((mode_q == MODE_FINISH) && (mode_d == MODE_FINISH)) begin
            if (tog_cnt_q == TOG_LAST) begin
                score_tog_d = ~score_tog_q;
            end else begin
                tog_cnt_d   = tog_cnt_q + TOG_W'(1);
                score_tog_d = score_tog_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q       <= MODE_IDLE;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            cd_cnt_q     <= '0;
            tog_cnt_q    <= '0;
            score_tog_q  <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            mode_q       <= mode_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            cd_cnt_q     <= cd_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            score_tog_q  <= score_tog_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (enter_cd),
        .inc   (score_inc),
        .score (score)
    );

    assign bus.mode      = mode_q;
    assign bus.score     = score;
    assign bus.miss_cnt  = miss_cnt_q;
    assign bus.score_tog = score_tog_q;
    assign bus.play_en   = (mode_q == MODE_PLAY);

endmodule

// File: tb/tb_game_mode_ctrl.sv
// tb/tb_game_mode_ctrl.sv - vector table plus scoreboard bench for game_mode_ctrl
module tb_game_mode_ctrl;
    import game_pkg::*;

    localparam int COUNT_CYCLES = 8;
    localparam int TOG_CYCLES   = 4;
    localparam int MAX_MISS     = 3;
    localparam int MISS_W       = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    game_mode_ctrl_if #(.MISS_W(MISS_W)) bus ();

    game_mode_ctrl #(
        .COUNT_CYCLES (COUNT_CYCLES),
        .TOG_CYCLES   (TOG_CYCLES),
        .MAX_MISS     (MAX_MISS),
        .MISS_W       (MISS_W)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        int                idx;
        logic              st, pa, hit, mis, done;
        mode_t             e_mode;
        logic [7:0]        e_score;
        logic [MISS_W-1:0] e_miss;
        logic              e_tog;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;

    function automatic logic [7:0] bcd_of(input int n);
        int k;
        k = (n > 99) ? 99 : n;
        return 8'((k / 10) * 16 + (k % 10));
    endfunction

    function automatic void add(input logic st, input logic pa, input logic hit,
                                input logic mis, input logic done, input mode_t m,
                                input int sc, input int mi, input logic t);
        vec_t v;
        v.idx = 0; v.st = st; v.pa = pa; v.hit = hit; v.mis = mis; v.done = done;
        v.e_mode = m; v.e_score = bcd_of(sc); v.e_miss = MISS_W'(mi); v.e_tog = t;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_pop();
        vec_t v;
        if (sb.size() > 0) begin
            v = sb.pop_front();
            chk("mode", v.idx, 32'(bus.mode), 32'(v.e_mode));
            chk("score", v.idx, 32'(bus.score), 32'(v.e_score));
            chk("miss_cnt", v.idx, 32'(bus.miss_cnt), 32'(v.e_miss));
            chk("score_tog", v.idx, 32'(bus.score_tog), 32'(v.e_tog));
            chk("play_en", v.idx, 32'(bus.play_en), 32'(v.e_mode == MODE_PLAY));
            chk("bcd_nibbles", v.idx,
                32'((bus.score[7:4] <= 4'd9) && (bus.score[3:0] <= 4'd9)), 32'd1);
        end
    endtask

    task automatic drive_idle();
        bus.start_btn = 1'b0; bus.pause_btn = 1'b0;
        bus.note_hit  = 1'b0; bus.note_miss = 1'b0; bus.song_done = 1'b0;
    endtask

    task automatic run_vecs();
        vec_t v;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge clk);
            check_pop();
            bus.start_btn = v.st; bus.pause_btn = v.pa;
            bus.note_hit  = v.hit; bus.note_miss = v.mis; bus.song_done = v.done;
            v.idx = vec_no++;
            sb.push_back(v);
        end
        @(negedge clk);
        check_pop();
        bus.note_hit = 1'b0; bus.note_miss = 1'b0; bus.song_done = 1'b0;
    endtask

    task automatic countdown_to_play();
        for (int k = 2; k <= COUNT_CYCLES; k++) add(0,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        add(0,0,0,0,0, MODE_PLAY, 0, 0, 0);
    endtask

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        chk("rst_mode", -1, 32'(bus.mode), 32'(MODE_IDLE));
        chk("rst_score", -1, 32'(bus.score), 32'h00);
        chk("rst_miss", -1, 32'(bus.miss_cnt), 32'd0);
        chk("rst_tog", -1, 32'(bus.score_tog), 32'd0);
        chk("rst_play_en", -1, 32'(bus.play_en), 32'd0);
        n_rst = 1'b1;

        // Game A: held start yields one countdown, then hits, pause, max-miss finish.
        for (int i = 1; i <= 20; i++)
            add(1,0,0,0,0, (i <= COUNT_CYCLES) ? MODE_COUNTDOWN : MODE_PLAY, 0, 0, 0);
        add(0,0,0,0,0, MODE_PLAY, 0, 0, 0);
        for (int n = 1; n <= 12; n++) add(0,0,1,0,0, MODE_PLAY, n, 0, 0);
        add(0,1,0,0,0, MODE_PAUSE, 12, 0, 0);
        add(0,1,1,0,0, MODE_PAUSE, 12, 0, 0);
        add(0,0,0,1,1, MODE_PAUSE, 12, 0, 0);
        add(0,1,0,0,0, MODE_PLAY, 12, 0, 0);
        add(0,0,0,0,0, MODE_PLAY, 12, 0, 0);
        for (int n = 13; n <= 112; n++) add(0,0,1,0,0, MODE_PLAY, n, 0, 0);
        add(0,0,0,1,0, MODE_PLAY, 99, 1, 0);
        add(0,0,0,1,0, MODE_PLAY, 99, 2, 0);
        add(0,0,0,1,0, MODE_FINISH, 99, 3, 0);
        for (int k = 1; k <= 8; k++)
            add(0,0,1,1,0, MODE_FINISH, 99, 3, logic'((k / TOG_CYCLES) % 2));

        // Game B: replay clears score; hit+miss+done in one cycle.
        add(1,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        countdown_to_play();
        add(0,0,1,0,0, MODE_PLAY, 1, 0, 0);
        add(0,0,1,0,0, MODE_PLAY, 2, 0, 0);
        add(0,0,1,1,1, MODE_FINISH, 3, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(0,0,1,0,0, MODE_FINISH, 3, 1, logic'((k / TOG_CYCLES) % 2));

        // Game C: song_done beats pause, replay, reach 45, pause.
        add(1,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        countdown_to_play();
        add(0,1,0,0,1, MODE_FINISH, 0, 0, 0);
        add(1,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        countdown_to_play();
        for (int n = 1; n <= 45; n++) add(0,0,1,0,0, MODE_PLAY, n, 0, 0);
        add(0,1,0,0,0, MODE_PAUSE, 45, 0, 0);
        run_vecs();

        // Asynchronous reset mid-PAUSE, away from any clock edge.
        #2;
        drive_idle();
        n_rst = 1'b0;
        #1;
        chk("async_mode", -2, 32'(bus.mode), 32'(MODE_IDLE));
        chk("async_score", -2, 32'(bus.score), 32'h00);
        chk("async_miss", -2, 32'(bus.miss_cnt), 32'd0);
        chk("async_tog", -2, 32'(bus.score_tog), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // After reset: pause/strobes ignored in PAUSE, start beats pause, IDLE ignores pause.
        add(1,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        countdown_to_play();
        add(0,1,0,0,0, MODE_PAUSE, 0, 0, 0);
        add(0,0,1,1,1, MODE_PAUSE, 0, 0, 0);
        add(1,1,0,0,0, MODE_IDLE, 0, 0, 0);
        add(0,0,0,0,0, MODE_IDLE, 0, 0, 0);
        add(0,1,1,1,1, MODE_IDLE, 0, 0, 0);
        add(1,0,0,0,0, MODE_COUNTDOWN, 0, 0, 0);
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
